// File: rtl/dbus_responder.sv
// dbus_responder: memory-side endpoint for the core's data/instruction bus.
// Accepts one request at a time, performs it on an internal word-addressed
// SRAM a fixed number of cycles after acceptance, and pulses resp_data_ok.
//
// Ports:
//   clk, resetn       rising-edge clock, asynchronous active-low reset
//   req_valid         request present, held by requester until data_ok
//   req_addr[31:0]    byte address (wraps modulo MEM_WORDS*4)
//   req_size[2:0]     0=byte, 1=half, others=word
//   req_strobe[3:0]   byte write enables, 4'b0000 = read
//   req_data[31:0]    write data, lanes aligned to addr[1:0]
//   resp_addr_ok      request accepted this cycle (combinational)
//   resp_data_ok      access complete, one-cycle pulse (registered)
//   resp_data[31:0]   pre-access word, held until the next data_ok
//   resp_err          misaligned request flag, valid with data_ok
//
// Optional: `define DBUS_RESP_STALL_EN adds 0..3 random extra wait cycles
// per access, drawn from an 8-bit LFSR.
module dbus_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned ADR_W = IDX_W + 2;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT             state;
  logic [CNT_W-1:0]  waitCnt;
  logic [CNT_W-1:0]  totalLat;
  logic [ADR_W-1:0]  addrQ;
  logic [2:0]        sizeQ;
  logic [3:0]        strobeQ;
  logic [31:0]       dataQ;
  logic              dataOkQ;
  logic [31:0]       respDataQ;
  logic              errQ;

  logic [ADR_W-1:0]  accAddr;
  logic [2:0]        accSize;
  logic [3:0]        accStrobe;
  logic [31:0]       accData;
  logic [IDX_W-1:0]  wordIdx;
  logic              misaligned;
  logic              accept;
  logic              enterResp;
  logic              memWe;
  logic [31:0]       rdWord;

  logic [31:0]       mem [MEM_WORDS];

  // Address bits above the SRAM index are intentionally discarded.
  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr[31:ADR_W];

`ifdef DBUS_RESP_STALL_EN
  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR; low two bits give the extra wait.
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign totalLat = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
  assign totalLat = CNT_W'(LATENCY);
`endif

  assign accept       = resetn && (state == IDLE) && req_valid;
  assign resp_addr_ok = accept;

  // In IDLE the access fields come straight from the request so that a
  // one-cycle latency can complete at the accept edge; otherwise latched.
  always_comb begin
    accAddr   = addrQ;
    accSize   = sizeQ;
    accStrobe = strobeQ;
    accData   = dataQ;
    if (state == IDLE) begin
      accAddr   = req_addr[ADR_W-1:0];
      accSize   = req_size;
      accStrobe = req_strobe;
      accData   = req_data;
    end
  end

  // Size 0 is always aligned, size 1 needs even address, anything else word.
  always_comb begin
    misaligned = 1'b0;
    case (accSize)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = accAddr[0];
      default: misaligned = (accAddr[1:0] != 2'b00);
    endcase
  end

  assign wordIdx = accAddr[ADR_W-1:2];
  assign rdWord  = mem[wordIdx];

  assign enterResp = (accept && (totalLat == CNT_W'(1))) ||
                     ((state == WAIT) && (waitCnt == CNT_W'(1)));
  assign memWe     = enterResp && !misaligned;

  // SRAM: no reset, byte-lane writes at the RESP-entry edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (memWe && accStrobe[i]) mem[wordIdx][8*i +: 8] <= accData[8*i +: 8];
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      waitCnt   <= '0;
      addrQ     <= '0;
      sizeQ     <= '0;
      strobeQ   <= '0;
      dataQ     <= '0;
      dataOkQ   <= 1'b0;
      respDataQ <= '0;
      errQ      <= 1'b0;
    end else begin
      dataOkQ <= enterResp;
      if (enterResp) begin
        respDataQ <= misaligned ? 32'h0 : rdWord;
        errQ      <= misaligned;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            addrQ   <= req_addr[ADR_W-1:0];
            sizeQ   <= req_size;
            strobeQ <= req_strobe;
            dataQ   <= req_data;
            if (totalLat == CNT_W'(1)) begin
              state <= RESP;
            end else begin
              state   <= WAIT;
              waitCnt <= totalLat - CNT_W'(1);
            end
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - CNT_W'(1);
          if (waitCnt == CNT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_data_ok = dataOkQ;
  assign resp_data    = respDataQ;
  assign resp_err     = errQ;

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: directed scenarios followed by
// randomized accesses compared against a word-array memory model.
module tb_dbus_responder;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned LATENCY   = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [31:0] resp_data;
  logic        resp_err;

  dbus_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_strobe   (req_strobe),
    .req_data     (req_data),
    .resp_addr_ok (resp_addr_ok),
    .resp_data_ok (resp_data_ok),
    .resp_data    (resp_data),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] modelMem   [MEM_WORDS];
  bit          modelKnown [MEM_WORDS];
  logic [31:0] lastRespData = 32'h0;
  bit          holdPrev     = 1'b0;
  int          prevOkCyc    = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit isMisaligned(input logic [31:0] addr, input logic [2:0] size);
    if (size == 3'd0) return 1'b0;
    if (size == 3'd1) return addr[0];
    return addr[1:0] != 2'b00;
  endfunction

  // One complete access: drive, check accept, wait for data_ok, check response.
  task automatic runAccess(input logic [31:0] addr, input logic [2:0] size,
                           input logic [3:0] strobe, input logic [31:0] data,
                           input bit holdAfter, input bit jitter,
                           output logic [31:0] gotData);
    logic [31:0] expData;
    bit expErr, expKnown, seen;
    int idx, lat;
    @(negedge clk);
    checkVal("data_ok_pulse", 32'(resp_data_ok), 32'd0);
    checkVal("resp_data_hold", resp_data, lastRespData);
    req_valid = 1'b1; req_addr = addr; req_size = size;
    req_strobe = strobe; req_data = data;
    #1;
    checkVal("addr_ok_accept", 32'(resp_addr_ok), 32'd1);
    expErr   = isMisaligned(addr, size);
    idx      = int'((addr >> 2) % MEM_WORDS);
    expKnown = expErr || modelKnown[idx];
    expData  = expErr ? 32'h0 : modelMem[idx];
    if (!expErr) begin
      for (int i = 0; i < 4; i++)
        if (strobe[i]) modelMem[idx][8*i +: 8] = data[8*i +: 8];
      if (strobe == 4'hF) modelKnown[idx] = 1'b1;
    end
    seen = 1'b0; lat = 0; gotData = 32'h0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk); #1;
      if (resp_data_ok) begin
        seen = 1'b1; lat = k;
`ifdef DBUS_RESP_STALL_EN
        checkVal("latency_range", 32'(lat >= LATENCY && lat <= LATENCY + 3), 32'd1);
`else
        checkVal("latency", 32'(lat), 32'(LATENCY));
        if (holdPrev) checkVal("hold_gap", 32'(cyc - prevOkCyc), 32'(LATENCY + 1));
`endif
        checkVal("addr_ok_resp", 32'(resp_addr_ok), 32'd0);
        checkVal("resp_err", 32'(resp_err), 32'(expErr));
        if (expKnown) checkVal("resp_data", resp_data, expData);
        gotData      = resp_data;
        lastRespData = resp_data;
        prevOkCyc    = cyc;
      end else begin
        checkVal("addr_ok_wait", 32'(resp_addr_ok), 32'd0);
        if (jitter) begin
          req_addr = $urandom; req_data = $urandom;
          req_size = 3'($urandom_range(0, 7)); req_strobe = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 1) == 1) req_valid = 1'b0;
        end
      end
    end
    checkVal("data_ok_seen", 32'(seen), 32'd1);
    holdPrev = holdAfter;
    if (!holdAfter) req_valid = 1'b0;
  endtask

  logic [31:0] got;
  logic [31:0] saved;

  initial begin
    resetn = 1'b0; req_valid = 1'b1; req_addr = 32'h0; req_size = 3'd2;
    req_strobe = 4'h0; req_data = 32'h0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      modelMem[i] = 32'h0; modelKnown[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    checkVal("rst_addr_ok", 32'(resp_addr_ok), 32'd0);
    checkVal("rst_data_ok", 32'(resp_data_ok), 32'd0);
    checkVal("rst_data", resp_data, 32'h0);
    checkVal("rst_err", 32'(resp_err), 32'd0);
    req_valid = 1'b0;
    @(negedge clk); resetn = 1'b1;

    // Preload the low 64 words so every later read is predictable.
    for (int i = 0; i < 64; i++)
      runAccess(32'(i) << 2, 3'd2, 4'hF, $urandom, 1'b0, 1'b0, got);

    // Word write then read back.
    runAccess(32'h10, 3'd2, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, got);
    runAccess(32'h10, 3'd2, 4'h0, 32'h0, 1'b0, 1'b0, got);
    checkVal("word_readback", got, 32'hDEADBEEF);

    // Single byte-lane write.
    runAccess(32'h20, 3'd2, 4'hF, 32'h11223344, 1'b0, 1'b0, got);
    runAccess(32'h20, 3'd0, 4'b0010, 32'h0000AB00, 1'b0, 1'b0, got);
    runAccess(32'h20, 3'd2, 4'h0, 32'h0, 1'b0, 1'b0, got);
    checkVal("byte_strobe", got, 32'h1122AB44);

    // Request held through RESP: next accept is the following cycle.
    runAccess(32'h24, 3'd2, 4'h0, 32'h0, 1'b1, 1'b0, got);
    runAccess(32'h24, 3'd2, 4'h0, 32'h0, 1'b0, 1'b0, got);

    // Misaligned word write is suppressed.
    runAccess(32'h22, 3'd2, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, got);
    checkVal("misaligned_data", got, 32'h0);
    runAccess(32'h20, 3'd2, 4'h0, 32'h0, 1'b0, 1'b0, got);
    checkVal("misaligned_nowrite", got, 32'h1122AB44);

    // Address wrap modulo MEM_WORDS*4.
    runAccess(32'h1000, 3'd2, 4'hF, 32'h55, 1'b0, 1'b0, got);
    runAccess(32'h0, 3'd2, 4'h0, 32'h0, 1'b0, 1'b0, got);
    checkVal("wrap_read", got, 32'h55);

    // Reset asserted while a write is waiting: write must be dropped.
    saved = modelMem[16];
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h40; req_size = 3'd2;
    req_strobe = 4'hF; req_data = ~saved;
    #1;
    checkVal("rstwait_accept", 32'(resp_addr_ok), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkVal("rstwait_addr_ok", 32'(resp_addr_ok), 32'd0);
    checkVal("rstwait_data_ok", 32'(resp_data_ok), 32'd0);
    checkVal("rstwait_data", resp_data, 32'h0);
    checkVal("rstwait_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    lastRespData = 32'h0;
    holdPrev = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checkVal("rstwait_no_data_ok", 32'(resp_data_ok), 32'd0);
    end
    runAccess(32'h40, 3'd2, 4'h0, 32'h0, 1'b0, 1'b0, got);
    checkVal("rstwait_unchanged", got, saved);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [3:0]  s;
      bit jit, hld;
      a   = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      s   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      jit = ($urandom_range(0, 1) == 1);
      hld = !jit && ($urandom_range(0, 3) == 0);
      runAccess(a, 3'($urandom_range(0, 7)), s, $urandom, hld, jit, got);
    end

    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
